// File: rtl/sbox_round_sequencer.sv
// -----------------------------------------------------------------------------
// sbox_round_sequencer
//
// Shares one external, purely combinational DES S-box bank across the eight
// 6-bit groups of a round's 48-bit expanded, key-mixed word. One group is
// looked up per cycle, in order S1..S8. The eight 4-bit results are assembled
// into the 32-bit substitution word that feeds the P-permutation.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_valid   data_in holds a word to be substituted
//   in_ready   sequencer can accept a word (IDLE only)
//   data_in    expanded word; group 1 = [47:42] ... group 8 = [5:0]
//   sbox_sel   index of the S-box being addressed (0 = S1 ... 7 = S8)
//   sbox_in    6-bit group presented to the selected S-box
//   sbox_en    a lookup is active this cycle
//   sbox_out   combinational bank result for sbox_sel/sbox_in
//   out_valid  data_out holds a complete result (DONE only)
//   out_ready  downstream accepts data_out
//   data_out   S1 result in [31:28] ... S8 result in [3:0]
//   busy       a word is in flight (RUN or DONE)
// -----------------------------------------------------------------------------
module sbox_round_sequencer #(
  parameter int NUM_BOXES = 8,
  parameter int GROUP_W   = 6,
  parameter int OUT_W     = 4,
  localparam int IDX_W    = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1,
  localparam int IN_W     = NUM_BOXES * GROUP_W,
  localparam int RES_W    = NUM_BOXES * OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  data_in,
  output logic [IDX_W-1:0] sbox_sel,
  output logic [GROUP_W-1:0] sbox_in,
  output logic             sbox_en,
  input  logic [OUT_W-1:0] sbox_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] data_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOXES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   idx_r;
  logic [IN_W-1:0]    data_reg_r;
  logic [RES_W-1:0]   data_out_r;

  // Group idx counts from the MSB end: group 0 (S1) is the top GROUP_W bits.
  function automatic logic [GROUP_W-1:0] select_group(
    input logic [IN_W-1:0]  word,
    input logic [IDX_W-1:0] idx
  );
    logic [GROUP_W-1:0] grp;
    grp = {GROUP_W{1'b0}};
    for (int b = 0; b < NUM_BOXES; b++) begin
      if (idx == IDX_W'(b)) begin
        grp = word[(NUM_BOXES-1-b)*GROUP_W +: GROUP_W];
      end
    end
    return grp;
  endfunction

  // State, lookup index, captured input word and assembled result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= {IDX_W{1'b0}};
      data_reg_r <= {IN_W{1'b0}};
      data_out_r <= {RES_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            data_reg_r <= data_in;
            data_out_r <= {RES_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
          end
        end
        ST_RUN: begin
          // Nibble for S(idx+1) lands at the matching position from the MSB end.
          for (int b = 0; b < NUM_BOXES; b++) begin
            if (idx_r == IDX_W'(b)) begin
              data_out_r[(NUM_BOXES-1-b)*OUT_W +: OUT_W] <= sbox_out;
            end
          end
          // Return to 0 after the last group instead of wrapping past NUM_BOXES-1.
          if (idx_r == LAST_IDX) begin
            idx_r <= {IDX_W{1'b0}};
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        ST_DONE: begin
          idx_r <= {IDX_W{1'b0}};
        end
        default: begin
          idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // Next-state decode and handshake / bank-address outputs from registered state.
  always_comb begin
    state_nxt_s = state_r;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    sbox_en     = 1'b0;
    sbox_sel    = {IDX_W{1'b0}};
    sbox_in     = {GROUP_W{1'b0}};
    busy        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        sbox_en  = 1'b1;
        sbox_sel = idx_r;
        sbox_in  = select_group(data_reg_r, idx_r);
        if (idx_r == LAST_IDX) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign data_out = data_out_r;

endmodule
